commit_scoreboard: RTL and testbench
====================================

COMMIT_SCOREBOARD -- requirements
Module: commit_scoreboard

Interface
REQ-001 SHALL have parameter AW, default 32, PC width.
REQ-002 SHALL have parameter DW, default 32, register write-data width.
REQ-003 SHALL have parameter DEPTH, default 8, per-stream FIFO entries; power of 2, >=2.
REQ-004 SHALL have parameter TIMEOUT, default 64, stall cycles before timeout error; >=1.
REQ-005 SHALL have parameter STOP_ON_ERR, default 1, freeze comparison after first error.
REQ-006 SHALL have parameter CHK_DATA, default 1, include write data in comparison.
REQ-007 clk  in  1  single clock; all state changes on rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-low.
REQ-009 a_valid / a_ready  in / out  1 / 1  DUT commit handshake.
REQ-010 a_pc, a_wen, a_waddr, a_wdata  in  AW, 1, 5, DW  DUT commit record.
REQ-011 b_valid / b_ready, b_pc, b_wen, b_waddr, b_wdata  same widths  golden-model commit stream.
REQ-012 clr  in  1  synchronous flush and status clear.
REQ-013 err  out  1  sticky error flag.
REQ-014 err_code  out  2  00 none, 01 PC mismatch, 10 register-write mismatch, 11 timeout.
REQ-015 err_idx  out  32  compare count at first error.
REQ-016 err_pc_a / err_pc_b  out  AW  PCs of the failing pair; for timeout, head PC of the non-empty stream, other 0.
REQ-017 cmp_count  out  32  matching pairs compared.
REQ-018 halt  out  1  stop request to the processor.

Function
REQ-019 Each stream SHALL buffer records in its own DEPTH-entry FIFO; x_ready = !full; push when x_valid && x_ready.
REQ-020 Records pushed at edge t SHALL be poppable at edge t+1; no bypass path.
REQ-021 FSM states SHALL be RUN and FAIL; reset state RUN.
REQ-022 In RUN, when both FIFOs are non-empty, both heads SHALL be popped in the same cycle and registered into a one-stage compare register.
REQ-023 Comparison SHALL be evaluated from the compare register; err SHALL rise one cycle after the pop edge, i.e. two edges after the later push.
REQ-024 Write normalisation: wen && waddr==0 SHALL be treated as wen=0; when normalised wen=0 on both sides, waddr/wdata SHALL be ignored.
REQ-025 PC mismatch SHALL take priority over register mismatch; register mismatch = wen differs, or both wen and (waddr differs, or CHK_DATA && wdata differs).
REQ-026 A matching pair SHALL increment cmp_count, wrapping modulo 2^32.
REQ-027 Stall counter SHALL increment while exactly one FIFO is non-empty; it SHALL clear on any pop or when both are empty.
REQ-028 Stall counter reaching TIMEOUT SHALL raise timeout error.
REQ-029 First error SHALL latch err, err_code, err_idx, err_pc_a, err_pc_b and enter FAIL; later errors SHALL NOT overwrite them.
REQ-030 In FAIL with STOP_ON_ERR=1: no pops, halt=1, FIFOs fill and deassert ready. With STOP_ON_ERR=0: pops and counting continue, halt=0.
REQ-031 Simultaneous push and pop on a non-empty FIFO SHALL leave occupancy unchanged; pointers SHALL wrap modulo DEPTH.
REQ-032 clr SHALL empty both FIFOs, zero the compare register, stall counter, cmp_count and all err outputs, and enter RUN; same-cycle pushes SHALL be discarded.
REQ-033 If a pair mismatches in the same cycle the stall counter reaches TIMEOUT, the compare result SHALL win.

Reset
REQ-034 rst low SHALL asynchronously empty both FIFOs, enter RUN, and set all outputs to 0 except a_ready=b_ready=1.
REQ-035 rst asserted mid-comparison SHALL discard the in-flight pair without updating any status.

Verification
REQ-036 Push 20 identical records on both streams, valid held high -> cmp_count=20, err=0, no ready drop.
REQ-037 Pair 5 has a_pc=0x00400010, b_pc=0x00400014 -> err=1, err_code=01, err_idx=4, err_pc_a/err_pc_b match, halt=1 two edges after push.
REQ-038 a_wen=1,a_waddr=0 vs b_wen=0 -> match; with CHK_DATA=0, wdata 0x1 vs 0x2 on waddr 3 -> match.
REQ-039 DEPTH=8, push 8 on A only -> a_ready=0 after 8th push; err_code=11 after 64 stall cycles.
REQ-040 After an error, clr pulse -> err=0, cmp_count=0, both ready=1; next matching pair counts 1.
REQ-041 rst low during pair 3 compare -> all outputs at reset values immediately, no err recorded.

Source files
------------

// File: rtl/commit_scoreboard.sv
// Commit-stream scoreboard: buffers DUT and golden-model commit records in
// two FIFOs, compares them pairwise and latches the first discrepancy or
// stall timeout.
module commit_scoreboard #(
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned TIMEOUT     = 64,
    parameter int unsigned STOP_ON_ERR = 1,
    parameter int unsigned CHK_DATA    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [AW-1:0] a_pc,
    input  logic          a_wen,
    input  logic [4:0]    a_waddr,
    input  logic [DW-1:0] a_wdata,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [AW-1:0] b_pc,
    input  logic          b_wen,
    input  logic [4:0]    b_waddr,
    input  logic [DW-1:0] b_wdata,
    input  logic          clr,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [31:0]   err_idx,
    output logic [AW-1:0] err_pc_a,
    output logic [AW-1:0] err_pc_b,
    output logic [31:0]   cmp_count,
    output logic          halt
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned RW = AW + 1 + 5 + DW;
    localparam int unsigned SW = $clog2(TIMEOUT + 1);

    typedef enum logic {RUN, FAIL} state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   mem_a_q [DEPTH];
    logic [RW-1:0]   mem_b_q [DEPTH];
    logic [PW-1:0]   a_wp_q, a_rp_q, b_wp_q, b_rp_q;
    logic [CW-1:0]   a_cnt_q, b_cnt_q;
    logic [RW-1:0]   ca_q, cb_q;
    logic            cvld_q;
    logic [SW-1:0]   stall_q, stall_d;
    logic            err_q, err_d;
    logic [1:0]      code_q, code_d;
    logic [31:0]     idx_q, idx_d, cnt_q, cnt_d;
    logic [AW-1:0]   pca_q, pca_d, pcb_q, pcb_d;

    logic            a_empty, b_empty, a_full, b_full, a_push, b_push;
    logic            can_pop, pop, eval, timeout;
    logic [RW-1:0]   head_a, head_b;
    logic            nwen_a, nwen_b, pc_mis, reg_mis;

    assign a_empty = (a_cnt_q == '0);
    assign b_empty = (b_cnt_q == '0);
    assign a_full  = (a_cnt_q == CW'(DEPTH));
    assign b_full  = (b_cnt_q == CW'(DEPTH));
    assign a_ready = !a_full;
    assign b_ready = !b_full;
    assign a_push  = a_valid && !a_full && !clr;
    assign b_push  = b_valid && !b_full && !clr;
    assign head_a  = mem_a_q[a_rp_q];
    assign head_b  = mem_b_q[b_rp_q];

    // With STOP_ON_ERR the FAIL state freezes popping and comparison.
    assign can_pop = (state_q == RUN) || (STOP_ON_ERR == 0);
    assign pop     = can_pop && !a_empty && !b_empty && !clr;
    assign eval    = cvld_q && can_pop;
    assign timeout = (stall_q == SW'(TIMEOUT));

    // A write to x0 is architecturally a no-op, so it is compared as no write.
    assign nwen_a  = ca_q[DW+5] && (ca_q[DW+4:DW] != 5'd0);
    assign nwen_b  = cb_q[DW+5] && (cb_q[DW+4:DW] != 5'd0);
    assign pc_mis  = (ca_q[RW-1 -: AW] != cb_q[RW-1 -: AW]);
    assign reg_mis = (nwen_a != nwen_b) ||
                     (nwen_a && nwen_b &&
                      ((ca_q[DW+4:DW] != cb_q[DW+4:DW]) ||
                       ((CHK_DATA != 0) && (ca_q[DW-1:0] != cb_q[DW-1:0]))));

    // FIFO storage writes (data only, no reset needed)
    always_ff @(posedge clk) begin
        if (a_push) mem_a_q[a_wp_q] <= {a_pc, a_wen, a_waddr, a_wdata};
        if (b_push) mem_b_q[b_wp_q] <= {b_pc, b_wen, b_waddr, b_wdata};
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_wp_q <= '0; a_rp_q <= '0; a_cnt_q <= '0;
            b_wp_q <= '0; b_rp_q <= '0; b_cnt_q <= '0;
        end else if (clr) begin
            a_wp_q <= '0; a_rp_q <= '0; a_cnt_q <= '0;
            b_wp_q <= '0; b_rp_q <= '0; b_cnt_q <= '0;
        end else begin
            if (a_push) a_wp_q <= a_wp_q + PW'(1);
            if (b_push) b_wp_q <= b_wp_q + PW'(1);
            if (pop) begin
                a_rp_q <= a_rp_q + PW'(1);
                b_rp_q <= b_rp_q + PW'(1);
            end
            a_cnt_q <= a_cnt_q + CW'(a_push) - CW'(pop);
            b_cnt_q <= b_cnt_q + CW'(b_push) - CW'(pop);
        end
    end

    // One-stage compare register loaded with both FIFO heads on a pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cvld_q <= 1'b0; ca_q <= '0; cb_q <= '0;
        end else if (clr) begin
            cvld_q <= 1'b0; ca_q <= '0; cb_q <= '0;
        end else begin
            cvld_q <= pop;
            if (pop) begin
                ca_q <= head_a;
                cb_q <= head_b;
            end
        end
    end

    // Stall counter: counts while exactly one stream has data, saturates
    always_comb begin
        stall_d = stall_q;
        if (pop || (a_empty && b_empty)) stall_d = '0;
        else if ((a_empty != b_empty) && !timeout) stall_d = stall_q + SW'(1);
    end

    // State and status registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN; stall_q <= '0; err_q <= 1'b0; code_q <= '0;
            idx_q <= '0; cnt_q <= '0; pca_q <= '0; pcb_q <= '0;
        end else begin
            state_q <= state_d; err_q <= err_d; code_q <= code_d;
            idx_q <= idx_d; cnt_q <= cnt_d; pca_q <= pca_d; pcb_q <= pcb_d;
            stall_q <= clr ? '0 : stall_d;
        end
    end

    // Next-state: compare result takes priority over a same-cycle timeout;
    // only the first error is latched
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        code_d  = code_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        pca_d   = pca_q;
        pcb_d   = pcb_q;
        if (clr) begin
            state_d = RUN;
            err_d   = 1'b0;
            code_d  = '0;
            idx_d   = '0;
            cnt_d   = '0;
            pca_d   = '0;
            pcb_d   = '0;
        end else if (eval && (pc_mis || reg_mis)) begin
            if (!err_q) begin
                state_d = FAIL;
                err_d   = 1'b1;
                code_d  = pc_mis ? 2'b01 : 2'b10;
                idx_d   = cnt_q;
                pca_d   = ca_q[RW-1 -: AW];
                pcb_d   = cb_q[RW-1 -: AW];
            end
        end else begin
            if (eval) cnt_d = cnt_q + 32'd1;
            if (timeout && !err_q) begin
                state_d = FAIL;
                err_d   = 1'b1;
                code_d  = 2'b11;
                idx_d   = cnt_q;
                pca_d   = a_empty ? '0 : head_a[RW-1 -: AW];
                pcb_d   = b_empty ? '0 : head_b[RW-1 -: AW];
            end
        end
    end

    assign err       = err_q;
    assign err_code  = code_q;
    assign err_idx   = idx_q;
    assign err_pc_a  = pca_q;
    assign err_pc_b  = pcb_q;
    assign cmp_count = cnt_q;
    assign halt      = (state_q == FAIL) && (STOP_ON_ERR != 0);

endmodule

// File: tb/tb_commit_scoreboard.sv
// Directed bench for commit_scoreboard: default instance plus a CHK_DATA=0
// instance sharing the same stimulus.
module tb_commit_scoreboard;

    logic        clk, rst, clr;
    logic        a_valid, a_wen, b_valid, b_wen;
    logic [31:0] a_pc, a_wdata, b_pc, b_wdata;
    logic [4:0]  a_waddr, b_waddr;

    logic        a_ready, b_ready, err, halt;
    logic [1:0]  err_code;
    logic [31:0] err_idx, err_pc_a, err_pc_b, cmp_count;

    logic        n_a_ready, n_b_ready, n_err, n_halt;
    logic [1:0]  n_err_code;
    logic [31:0] n_err_idx, n_err_pc_a, n_err_pc_b, n_cmp_count;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic        ready_drop;

    commit_scoreboard u_dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_pc(a_pc), .a_wen(a_wen),
        .a_waddr(a_waddr), .a_wdata(a_wdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_pc(b_pc), .b_wen(b_wen),
        .b_waddr(b_waddr), .b_wdata(b_wdata),
        .clr(clr), .err(err), .err_code(err_code), .err_idx(err_idx),
        .err_pc_a(err_pc_a), .err_pc_b(err_pc_b), .cmp_count(cmp_count),
        .halt(halt)
    );

    commit_scoreboard #(.CHK_DATA(0)) u_nd (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(n_a_ready), .a_pc(a_pc), .a_wen(a_wen),
        .a_waddr(a_waddr), .a_wdata(a_wdata),
        .b_valid(b_valid), .b_ready(n_b_ready), .b_pc(b_pc), .b_wen(b_wen),
        .b_waddr(b_waddr), .b_wdata(b_wdata),
        .clr(clr), .err(n_err), .err_code(n_err_code), .err_idx(n_err_idx),
        .err_pc_a(n_err_pc_a), .err_pc_b(n_err_pc_b), .cmp_count(n_cmp_count),
        .halt(n_halt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_a(input logic [31:0] pc, input logic wen, input logic [4:0] wa, input logic [31:0] wd);
        a_pc = pc; a_wen = wen; a_waddr = wa; a_wdata = wd;
    endtask

    task automatic set_b(input logic [31:0] pc, input logic wen, input logic [4:0] wa, input logic [31:0] wd);
        b_pc = pc; b_wen = wen; b_waddr = wa; b_wdata = wd;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        clr = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        set_a(32'h0, 1'b0, 5'd0, 32'h0);
        set_b(32'h0, 1'b0, 5'd0, 32'h0);
        rst = 1'b1;
        #1 rst = 1'b0;
        #3;
        check("rst_a_ready", a_ready, 1);
        check("rst_b_ready", b_ready, 1);
        check("rst_err", err, 0);
        check("rst_err_code", err_code, 0);
        check("rst_cmp_count", cmp_count, 0);
        check("rst_halt", halt, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // 20 identical records, valid held high
        ready_drop = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_a(32'h1000 + 32'(4 * i), 1'b1, 5'(i + 1), 32'(i * 7));
            set_b(32'h1000 + 32'(4 * i), 1'b1, 5'(i + 1), 32'(i * 7));
            if (!(a_ready && b_ready)) ready_drop = 1'b1;
            step();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (3) step();
        check("stream20_count", cmp_count, 20);
        check("stream20_err", err, 0);
        check("stream20_ready", ready_drop, 0);

        pulse_clr();
        check("clr_count", cmp_count, 0);

        // PC mismatch on pair 5
        a_valid = 1'b1; b_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_a(32'h00400000 + 32'(4 * i), 1'b1, 5'd5, 32'(i));
            set_b((i == 4) ? 32'h00400014 : 32'h00400000 + 32'(4 * i), 1'b1, 5'd5, 32'(i));
            step();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        step();
        check("pcmis_err_early", err, 0);
        step();
        check("pcmis_err", err, 1);
        check("pcmis_code", err_code, 2'b01);
        check("pcmis_idx", err_idx, 4);
        check("pcmis_pc_a", err_pc_a, 32'h00400010);
        check("pcmis_pc_b", err_pc_b, 32'h00400014);
        check("pcmis_halt", halt, 1);

        // Frozen after error: FIFOs fill, status not overwritten
        a_valid = 1'b1; b_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_a(32'h5000 + 32'(4 * i), 1'b1, 5'd1, 32'h1);
            set_b(32'h6000 + 32'(4 * i), 1'b0, 5'd2, 32'h2);
            step();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        step();
        check("frozen_a_ready", a_ready, 0);
        check("frozen_b_ready", b_ready, 0);
        check("frozen_count", cmp_count, 4);
        check("frozen_code", err_code, 2'b01);
        check("frozen_idx", err_idx, 4);

        // Clear after error, then one matching pair
        pulse_clr();
        check("clr_err", err, 0);
        check("clr_code", err_code, 0);
        check("clr_count2", cmp_count, 0);
        check("clr_a_ready", a_ready, 1);
        check("clr_b_ready", b_ready, 1);
        check("clr_halt", halt, 0);
        a_valid = 1'b1; b_valid = 1'b1;
        set_a(32'h7000, 1'b1, 5'd9, 32'hAB);
        set_b(32'h7000, 1'b1, 5'd9, 32'hAB);
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (2) step();
        check("after_clr_count", cmp_count, 1);
        check("after_clr_err", err, 0);

        // Write normalisation and CHK_DATA
        pulse_clr();
        a_valid = 1'b1; b_valid = 1'b1;
        set_a(32'h2000, 1'b1, 5'd0, 32'h5);
        set_b(32'h2000, 1'b0, 5'd7, 32'h9);
        step();
        set_a(32'h2004, 1'b1, 5'd3, 32'h1);
        set_b(32'h2004, 1'b1, 5'd3, 32'h2);
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (3) step();
        check("data_err", err, 1);
        check("data_code", err_code, 2'b10);
        check("data_idx", err_idx, 1);
        check("data_pc_a", err_pc_a, 32'h2004);
        check("nodata_err", n_err, 0);
        check("nodata_count", n_cmp_count, 2);

        // Timeout with only stream A
        pulse_clr();
        a_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_a(32'h3000 + 32'(4 * i), 1'b0, 5'd0, 32'h0);
            step();
        end
        a_valid = 1'b0;
        check("full_a_ready", a_ready, 0);
        check("full_b_ready", b_ready, 1);
        repeat (50) step();
        check("stall_err_early", err, 0);
        repeat (10) step();
        check("timeout_err", err, 1);
        check("timeout_code", err_code, 2'b11);
        check("timeout_pc_a", err_pc_a, 32'h3000);
        check("timeout_pc_b", err_pc_b, 0);
        check("timeout_idx", err_idx, 0);
        check("timeout_halt", halt, 1);

        // Reset while pair 3 (mismatching) is in the compare register
        pulse_clr();
        a_valid = 1'b1; b_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_a(32'h8000 + 32'(4 * i), 1'b0, 5'd0, 32'h0);
            set_b((i == 2) ? 32'h9999 : 32'h8000 + 32'(4 * i), 1'b0, 5'd0, 32'h0);
            step();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        step();
        check("pre_rst_count", cmp_count, 2);
        #1 rst = 1'b0;
        #1;
        check("midrst_err", err, 0);
        check("midrst_code", err_code, 0);
        check("midrst_count", cmp_count, 0);
        check("midrst_a_ready", a_ready, 1);
        check("midrst_b_ready", b_ready, 1);
        check("midrst_halt", halt, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) step();
        check("postrst_err", err, 0);
        check("postrst_count", cmp_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
